// File: rtl/cpu_harness_ctrl_if.sv
// Bus and control bundle between a CPU-core bench driver and the run controller.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: none; clk_en is the only qualifier and travels with the bus.
interface cpu_harness_ctrl_if #(
    parameter int ADDR_W  = 21,
    parameter int NUM_IRQ = 3,
    parameter int CYC_W   = 32
);
    logic                       clk_en;
    logic [ADDR_W-1:0]          addr;
    logic                       re;
    logic [NUM_IRQ*CYC_W-1:0]   irq_at;
    logic [CYC_W-1:0]           timeout_cycles;
    logic                       cpu_reset;
    logic [NUM_IRQ-1:0]         irq_n;
    logic                       done;
    logic                       pass;
    logic                       timeout;
    logic [CYC_W-1:0]           cycle_count;
    logic [7:0]                 hit_count;

    // Bench / core side: drives bus observations and run configuration.
    modport master (
        output clk_en, addr, re, irq_at, timeout_cycles,
        input  cpu_reset, irq_n, done, pass, timeout, cycle_count, hit_count
    );

    // Controller side.
    modport slave (
        input  clk_en, addr, re, irq_at, timeout_cycles,
        output cpu_reset, irq_n, done, pass, timeout, cycle_count, hit_count
    );
endinterface

// File: rtl/cpu_harness_ctrl.sv
// Run controller for CPU-core regression: reset release, IRQ injection, halt/timeout detect.
// Latency: all outputs registered; an event on an enabled cycle is visible after the next edge.
// Backpressure: none; clk_en low freezes every counter, state and output.
module cpu_harness_ctrl #(
    parameter int                ADDR_W     = 21,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = 21'h00beef,
    parameter logic [ADDR_W-1:0] HALT_MASK  = 21'h00ffff,
    parameter int                HALT_HITS  = 1,
    parameter int                NUM_IRQ    = 3,
    parameter int                CYC_W      = 32,
    parameter int                RST_CYCLES = 2,
    parameter int                IRQ_LEN    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    cpu_harness_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_hold_cnt;
    logic               r_cpu_reset;
    logic               r_done;
    logic               r_pass;
    logic               r_timeout;
    logic [CYC_W-1:0]   r_cycle;
    logic [7:0]         r_hits;
    logic [NUM_IRQ-1:0] r_irq_n;
    logic [NUM_IRQ-1:0] r_fired;
    logic [31:0]        r_irq_len [NUM_IRQ];

    logic               w_hit;
    logic [7:0]         w_hits_next;
    logic               w_halt_done;
    logic               w_tmo_hit;
    logic [CYC_W-1:0]   w_irq_at [NUM_IRQ];
    logic [NUM_IRQ-1:0] w_irq_sched;

    // Halt read qualification and timeout compare; hit count saturates at 255.
    always_comb begin
        w_hit       = bus.re && (((bus.addr ^ HALT_ADDR) & HALT_MASK) == '0);
        w_hits_next = (r_hits == 8'hff) ? r_hits : r_hits + 8'd1;
        w_halt_done = w_hit && (w_hits_next == 8'(HALT_HITS));
        w_tmo_hit   = (bus.timeout_cycles != '0) &&
                      (r_cycle == bus.timeout_cycles - CYC_W'(1));
    end

    // Per-channel schedule match one cycle early so irq_n drops on the scheduled cycle.
    always_comb begin
        w_irq_sched = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_irq_at[i]    = bus.irq_at[i*CYC_W +: CYC_W];
            w_irq_sched[i] = (w_irq_at[i] != '0) && (r_cycle == w_irq_at[i] - CYC_W'(1));
        end
    end

    // Run sequencer: HOLD counts reset cycles, RUN counts and watches, DONE freezes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycle     <= '0;
            r_hits      <= '0;
            r_irq_n     <= '1;
            r_fired     <= '0;
            for (int i = 0; i < NUM_IRQ; i++) r_irq_len[i] <= '0;
        end else if (bus.clk_en) begin
            case (r_state)
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 32'd1;
                    if (r_hold_cnt == 32'(RST_CYCLES - 1)) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_hit) r_hits <= w_hits_next;
                    // Halt takes priority over a coincident timeout.
                    if (w_halt_done) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                        r_irq_n <= '1;
                    end else if (w_tmo_hit) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_irq_n   <= '1;
                    end else begin
                        r_cycle <= r_cycle + CYC_W'(1);
                        for (int i = 0; i < NUM_IRQ; i++) begin
                            if (!r_irq_n[i]) begin
                                // Asserted channel: hold for IRQ_LEN enabled cycles, ignore schedule.
                                if (r_irq_len[i] == 32'(IRQ_LEN - 1)) r_irq_n[i] <= 1'b1;
                                else r_irq_len[i] <= r_irq_len[i] + 32'd1;
                            end else if (w_irq_sched[i] && !r_fired[i]) begin
                                r_irq_n[i]   <= 1'b0;
                                r_irq_len[i] <= '0;
                                r_fired[i]   <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    assign bus.cpu_reset   = r_cpu_reset;
    assign bus.irq_n       = r_irq_n;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.timeout     = r_timeout;
    assign bus.cycle_count = r_cycle;
    assign bus.hit_count   = r_hits;

endmodule

// File: tb/tb_cpu_harness_ctrl.sv
// Bench for cpu_harness_ctrl: two instances (HALT_HITS 1 and 3) share one randomized stimulus.
// Latency: outputs sampled 1 ns after each rising edge and compared with an event-level model.
// Backpressure: clk_en is randomly withheld; the model only advances on enabled edges.
module tb_cpu_harness_ctrl;

    localparam int ADDR_W     = 21;
    localparam int NUM_IRQ    = 3;
    localparam int CYC_W      = 32;
    localparam int RST_CYCLES = 2;
    localparam int IRQ_LEN    = 4;
    localparam logic [20:0] HALT_ADDR = 21'h00beef;
    localparam logic [20:0] HALT_MASK = 21'h00ffff;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    cpu_harness_ctrl_if #(.ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ), .CYC_W(CYC_W)) bus1 ();
    cpu_harness_ctrl_if #(.ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ), .CYC_W(CYC_W)) bus3 ();

    cpu_harness_ctrl #(
        .ADDR_W(ADDR_W), .HALT_ADDR(HALT_ADDR), .HALT_MASK(HALT_MASK), .HALT_HITS(1),
        .NUM_IRQ(NUM_IRQ), .CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES), .IRQ_LEN(IRQ_LEN)
    ) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    cpu_harness_ctrl #(
        .ADDR_W(ADDR_W), .HALT_ADDR(HALT_ADDR), .HALT_MASK(HALT_MASK), .HALT_HITS(3),
        .NUM_IRQ(NUM_IRQ), .CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES), .IRQ_LEN(IRQ_LEN)
    ) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counts of enabled edges, hits and the cycle the run ended.
    int m_en;
    int m_hits    [2];
    int m_done_at [2];
    bit m_pass    [2];
    bit m_tmo     [2];
    int m_at      [NUM_IRQ];
    int m_tmo_cyc;
    int hh        [2] = '{1, 3};
    int tgt_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0;
        for (int k = 0; k < 2; k++) begin
            m_hits[k] = 0; m_done_at[k] = -1; m_pass[k] = 0; m_tmo[k] = 0;
        end
    endtask

    task automatic model_edge(input bit en, input bit r, input logic [20:0] a);
        int n;
        bit hit;
        if (!en) return;
        n   = m_en - RST_CYCLES;
        hit = r && (((a ^ HALT_ADDR) & HALT_MASK) == 21'd0);
        for (int k = 0; k < 2; k++) begin
            if (n >= 0 && m_done_at[k] < 0) begin
                if (hit) m_hits[k]++;
                if (hit && m_hits[k] == hh[k]) begin
                    m_done_at[k] = n; m_pass[k] = 1;
                end else if (m_tmo_cyc != 0 && n == m_tmo_cyc - 1) begin
                    m_done_at[k] = n; m_tmo[k] = 1;
                end
            end
        end
        m_en++;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic cr, dn, ps, to;
            logic [NUM_IRQ-1:0] irq, e_irq;
            logic [31:0] cc;
            logic [7:0] hc;
            int e_cc;
            if (k == 0) begin
                cr = bus1.cpu_reset; irq = bus1.irq_n; dn = bus1.done; ps = bus1.pass;
                to = bus1.timeout; cc = bus1.cycle_count; hc = bus1.hit_count;
            end else begin
                cr = bus3.cpu_reset; irq = bus3.irq_n; dn = bus3.done; ps = bus3.pass;
                to = bus3.timeout; cc = bus3.cycle_count; hc = bus3.hit_count;
            end
            e_irq = '1;
            if (m_done_at[k] >= 0) begin
                e_cc = m_done_at[k];
            end else begin
                e_cc = (m_en >= RST_CYCLES) ? m_en - RST_CYCLES : 0;
                for (int i = 0; i < NUM_IRQ; i++)
                    if (m_at[i] != 0 && m_en >= RST_CYCLES && e_cc >= m_at[i] && e_cc < m_at[i] + IRQ_LEN)
                        e_irq[i] = 1'b0;
            end
            check($sformatf("cpu_reset[%0d]", k), 64'(cr), 64'(m_en < RST_CYCLES));
            check($sformatf("irq_n[%0d]", k), 64'(irq), 64'(e_irq));
            check($sformatf("done[%0d]", k), 64'(dn), 64'(m_done_at[k] >= 0));
            check($sformatf("pass[%0d]", k), 64'(ps), 64'(m_pass[k]));
            check($sformatf("timeout[%0d]", k), 64'(to), 64'(m_tmo[k]));
            check($sformatf("cycle_count[%0d]", k), 64'(cc), 64'(e_cc));
            check($sformatf("hit_count[%0d]", k), 64'(hc), 64'((m_hits[k] > 255) ? 255 : m_hits[k]));
        end
    endtask

    task automatic drive(input bit en, input bit r, input logic [20:0] a);
        bus1.clk_en = en; bus1.re = r; bus1.addr = a;
        bus3.clk_en = en; bus3.re = r; bus3.addr = a;
    endtask

    task automatic set_cfg(input int a0, input int a1, input int a2, input int t);
        m_at[0] = a0; m_at[1] = a1; m_at[2] = a2; m_tmo_cyc = t;
        bus1.irq_at = {32'(a2), 32'(a1), 32'(a0)};
        bus3.irq_at = {32'(a2), 32'(a1), 32'(a0)};
        bus1.timeout_cycles = 32'(t);
        bus3.timeout_cycles = 32'(t);
    endtask

    // Asynchronous assert away from any edge, check reset values, release mid-cycle.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic run(input int ncyc, input int en_pct, input int rd_pct);
        for (int c = 0; c < ncyc; c++) begin
            bit en, r, tgt;
            logic [20:0] a;
            int n;
            en  = ($urandom_range(99) < en_pct);
            n   = m_en - RST_CYCLES;
            tgt = 1'b0;
            foreach (tgt_q[j]) if (tgt_q[j] == n) tgt = 1'b1;
            a = 21'($urandom);
            r = 1'($urandom);
            if (a[15:0] == 16'hbeef) a[0] = ~a[0];
            if (en && tgt) begin
                r = 1'b1; a = 21'h1fbeef;
            end else if ($urandom_range(99) < rd_pct) begin
                r = 1'b1; a[15:0] = 16'hbeef;
            end else if ($urandom_range(9) == 0) begin
                r = 1'b0; a[15:0] = 16'hbeef;
            end
            drive(en, r, a);
            @(posedge clk);
            #1;
            model_edge(en, r, a);
            check_all();
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 21'd0);
        set_cfg(0, 0, 0, 0);
        model_reset();
        #2;

        // Reset release, IRQ schedule and a single halt read at cycle 100.
        set_cfg(5, 20, 0, 0);
        tgt_q = '{100};
        do_reset();
        run(130, 100, 0);

        // Three halt reads: instance with HALT_HITS=3 finishes only on the third.
        set_cfg(0, 0, 0, 0);
        tgt_q = '{10, 20, 30};
        do_reset();
        run(45, 100, 0);

        // Timeout with no halt, then halt on the timeout cycle.
        set_cfg(0, 0, 0, 50);
        tgt_q = {};
        do_reset();
        run(60, 100, 0);
        tgt_q = '{49};
        do_reset();
        run(60, 100, 0);

        // IRQ schedule under 50% clk_en.
        set_cfg(5, 20, 0, 0);
        tgt_q = {};
        do_reset();
        run(90, 50, 0);

        // Reset pulse while channel 0 is asserted (cycle 7), then full restart.
        do_reset();
        run(RST_CYCLES + 7, 100, 0);
        check("irq0_active_before_pulse", 64'(bus1.irq_n[0]), 64'd0);
        #3;
        do_reset();
        run(40, 100, 0);

        // Randomized runs.
        for (int t = 0; t < 8; t++) begin
            int a0, a1, a2, tm;
            a0 = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(60, 1));
            a1 = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(60, 1));
            a2 = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(60, 1));
            tm = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(150, 30));
            set_cfg(a0, a1, a2, tm);
            tgt_q = {};
            do_reset();
            run(200, int'($urandom_range(100, 40)), 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
